// File: rtl/eth_pkg.sv
// Shared types and defaults for the Ethernet transmit scheduler (eth_tx_sched).
package eth_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_GRANT   = 3'd1,
      ST_WAIT_TX = 3'd2,
      ST_SEND    = 3'd3,
      ST_IFG     = 3'd4
   } state_e;

   localparam int unsigned DEF_IFG_CYCLES = 12;
   localparam int unsigned DEF_TMO_CYCLES = 4096;

   // Shared counter must hold the larger of the two terminal counts without wrapping.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      return $clog2((a > b) ? a : b) + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: search starts one past the last granted index.
module rr_arbiter #(
   parameter int unsigned NREQ = 3
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [2:0]      i_last,
   output logic [NREQ-1:0] o_gnt,
   output logic [2:0]      o_idx,
   output logic            o_valid
);

   int unsigned j;

   always_comb begin
      o_gnt   = '0;
      o_idx   = i_last;
      o_valid = 1'b0;
      j       = 0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         j = (int'(i_last) + k) % NREQ;
         if (!o_valid && i_req[j]) begin
            o_valid  = 1'b1;
            o_gnt[j] = 1'b1;
            o_idx    = 3'(j);
         end
      end
   end

endmodule

// File: rtl/eth_tx_sched.sv
// Transmit scheduler: round-robin grants a shared MAC engine, enforces IFG and start timeout.
// Optional statistics counters enabled with macro ETH_TX_SCHED_STATS_EN.
module eth_tx_sched
   import eth_pkg::*;
#(
   parameter int unsigned NREQ       = 3,
   parameter int unsigned IFG_CYCLES = DEF_IFG_CYCLES,
   parameter int unsigned TMO_CYCLES = DEF_TMO_CYCLES
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] i_req,
   output logic [NREQ-1:0] o_gnt,
   output logic            o_start,
   input  logic            i_tx_en,
   output logic [NREQ-1:0] o_done,
   output logic [NREQ-1:0] o_abort,
   output logic            o_busy,
   output logic [2:0]      o_sel
`ifdef ETH_TX_SCHED_STATS_EN
   ,
   output logic [15:0]     o_frame_cnt,
   output logic [7:0]      o_tmo_cnt
`endif
);

   localparam int unsigned     CW       = cnt_width(IFG_CYCLES, TMO_CYCLES);
   localparam logic [CW-1:0]   TMO_LAST = CW'(TMO_CYCLES - 1);
   localparam logic [CW-1:0]   IFG_LAST = CW'(IFG_CYCLES - 1);
   localparam logic [2:0]      SEL_RST  = 3'(NREQ - 1);

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [2:0]        sel_q, sel_d;
   logic [NREQ-1:0]   arb_gnt;
   logic [2:0]        arb_idx;
   logic              arb_valid;
   logic              done_ev;
   logic              abort_ev;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .i_req   (i_req),
      .i_last  (sel_q),
      .o_gnt   (arb_gnt),
      .o_idx   (arb_idx),
      .o_valid (arb_valid)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      gnt_d    = gnt_q;
      sel_d    = sel_q;
      done_ev  = 1'b0;
      abort_ev = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (arb_valid) begin
               state_d = ST_GRANT;
               gnt_d   = arb_gnt;
               sel_d   = arb_idx;
            end
         end
         ST_GRANT: begin
            state_d = ST_WAIT_TX;
            cnt_d   = '0;
         end
         ST_WAIT_TX: begin
            // tx_en is checked first so it wins over a coincident timeout
            if (i_tx_en) begin
               state_d = ST_SEND;
               cnt_d   = '0;
            end else if (cnt_q == TMO_LAST) begin
               abort_ev = 1'b1;
               state_d  = ST_IDLE;
               gnt_d    = '0;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_SEND: begin
            if (!i_tx_en) begin
               done_ev = 1'b1;
               state_d = ST_IFG;
               cnt_d   = '0;
            end
         end
         ST_IFG: begin
            if (cnt_q == IFG_LAST) begin
               state_d = ST_IDLE;
               gnt_d   = '0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         gnt_q   <= '0;
         sel_q   <= SEL_RST;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
      end
   end

   assign o_gnt   = gnt_q;
   assign o_start = (state_q == ST_GRANT);
   assign o_done  = done_ev ? gnt_q : '0;
   assign o_abort = abort_ev ? gnt_q : '0;
   assign o_busy  = (state_q != ST_IDLE);
   assign o_sel   = sel_q;

`ifdef ETH_TX_SCHED_STATS_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [7:0]  tmo_cnt_q, tmo_cnt_d;

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      if (done_ev) frame_cnt_d = frame_cnt_q + 16'd1;
      if (abort_ev && tmo_cnt_q != 8'hFF) tmo_cnt_d = tmo_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_q <= '0;
         tmo_cnt_q   <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
      end
   end

   assign o_frame_cnt = frame_cnt_q;
   assign o_tmo_cnt   = tmo_cnt_q;
`endif

endmodule

// File: tb/tb_eth_tx_sched.sv
// Self-checking bench for eth_tx_sched against a frame-level scheduling model.
module tb_eth_tx_sched;

   localparam int unsigned NREQ = 3;
   localparam int unsigned IFG  = 12;
   localparam int unsigned TMO  = 40;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [NREQ-1:0] i_req = '0;
   logic            i_tx_en = 1'b0;
   logic [NREQ-1:0] o_gnt, o_done, o_abort;
   logic            o_start, o_busy;
   logic [2:0]      o_sel;
`ifdef ETH_TX_SCHED_STATS_EN
   logic [15:0]     o_frame_cnt;
   logic [7:0]      o_tmo_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   logic [NREQ-1:0] req_prev = '0;
   int model_last = NREQ - 1;
   int fall_cyc = 0;
   bit fall_valid = 1'b0;
   int exp_frames = 0;
   int exp_tmo = 0;

   always #5 clk = ~clk;

   eth_tx_sched #(.NREQ(NREQ), .IFG_CYCLES(IFG), .TMO_CYCLES(TMO)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_req   (i_req),
      .o_gnt   (o_gnt),
      .o_start (o_start),
      .i_tx_en (i_tx_en),
      .o_done  (o_done),
      .o_abort (o_abort),
      .o_busy  (o_busy),
      .o_sel   (o_sel)
`ifdef ETH_TX_SCHED_STATS_EN
      ,
      .o_frame_cnt (o_frame_cnt),
      .o_tmo_cnt   (o_tmo_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are read on the falling edge.
   task automatic adv(input logic [NREQ-1:0] req, input logic tx);
      @(posedge clk);
      req_prev = i_req;
      #1;
      i_req   = req;
      i_tx_en = tx;
      cyc++;
      @(negedge clk);
   endtask

   function automatic int winner(input logic [NREQ-1:0] req, input int last);
      for (int k = 1; k <= NREQ; k++) begin
         if (req[(last + k) % NREQ]) return (last + k) % NREQ;
      end
      return -1;
   endfunction

   // One frame: wait for start, then either let the engine run or let it time out.
   task automatic do_frame(input logic [NREQ-1:0] req, input int d, input int len,
                           input bit tmo, input bit drop, output int wait_n, output int sel_o);
      int w;
      int exp_idx;
      int t0;
      logic [NREQ-1:0] cur;
      logic [NREQ-1:0] spur;
      cur  = req;
      spur = '0;
      w    = 0;
      do begin
         adv(cur, 1'b0);
         w++;
      end while (!o_start && w < 200);
      wait_n = w;
      sel_o  = o_sel;
      chk("start_seen", 32'(o_start), 1);
      exp_idx = winner(req_prev, model_last);
      if (exp_idx < 0) exp_idx = 0;
      chk("sel", 32'(o_sel), exp_idx);
      chk("gnt_onehot", 32'(o_gnt), 32'(1) << exp_idx);
      if (fall_valid) chk("ifg_gap", 32'((cyc - fall_cyc) >= int'(IFG + 1)), 1);
      fall_valid = 1'b0;
      model_last = exp_idx;
      t0 = cyc;
      if (tmo) begin
         w = 0;
         do begin
            adv(cur, 1'b0);
            w++;
         end while (o_abort == '0 && w < int'(TMO) + 20);
         chk("abort_vec", 32'(o_abort), 32'(1) << exp_idx);
         chk("abort_latency", cyc - t0, TMO);
         if (exp_tmo < 255) exp_tmo++;
         adv(cur, 1'b0);
         chk("idle_after_abort", {o_busy, o_gnt}, 0);
      end else begin
         for (int i = 1; i < d; i++) begin
            adv(cur, 1'b0);
            spur |= o_abort | o_done;
         end
         adv(cur, 1'b1);
         chk("no_abort_when_tx", 32'(o_abort), 0);
         for (int i = 1; i < len; i++) begin
            if (drop && i == len / 2) cur[exp_idx] = 1'b0;
            adv(cur, 1'b1);
            spur |= o_abort | o_done;
         end
         chk("no_early_pulse", 32'(spur), 0);
         adv(cur, 1'b0);
         chk("done_vec", 32'(o_done), 32'(1) << exp_idx);
         fall_cyc   = cyc;
         fall_valid = 1'b1;
         exp_frames++;
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "simulation watchdog expired");
   end

   initial begin
      int w;
      int s;
      logic [NREQ-1:0] rq;
      logic [NREQ-1:0] spur;

      // Reset values
      repeat (3) adv('0, 1'b0);
      chk("rst_outputs", {o_gnt, o_start, o_done, o_abort, o_busy}, 0);
      chk("rst_sel", 32'(o_sel), NREQ - 1);
      @(posedge clk); #1; rst_n = 1'b1;
      @(negedge clk);

      // tx_en in IDLE is ignored
      repeat (3) adv('0, 1'b1);
      chk("idle_tx_ignored", {o_busy, o_start}, 0);
      adv('0, 1'b0);

      // All requesting: rotation 0,1,2,0,1,2
      for (int i = 0; i < 6; i++) begin
         do_frame(3'b111, $urandom_range(1, 5), $urandom_range(1, 10), 1'b0, 1'b0, w, s);
         chk("rotation", s, i % NREQ);
      end

      // Single requester, 64-cycle frame, then a second frame checking IFG spacing
      repeat (IFG + 3) adv('0, 1'b0);
      do_frame(3'b001, 1, 64, 1'b0, 1'b0, w, s);
      chk("req_to_start_latency", w - 1, 1);
      chk("single_sel", s, 0);
      do_frame(3'b001, 2, 5, 1'b0, 1'b0, w, s);

      // Timeout, next requester granted
      do_frame(3'b011, 0, 0, 1'b1, 1'b0, w, s);
      do_frame(3'b011, 3, 4, 1'b0, 1'b0, w, s);

      // tx_en arriving on the timeout cycle wins
      do_frame(3'b100, TMO, 5, 1'b0, 1'b0, w, s);

      // Requester 1 drops request mid-frame
      do_frame(3'b010, 3, 10, 1'b0, 1'b1, w, s);
      chk("drop_sel", s, 1);

      // Reset during SEND
      w = 0;
      do begin
         adv(3'b111, 1'b0);
         w++;
      end while (!o_start && w < 200);
      adv(3'b111, 1'b1);
      adv(3'b111, 1'b1);
      @(posedge clk); #1; rst_n = 1'b0; #1;
      chk("rst_mid_outputs", {o_gnt, o_start, o_done, o_abort, o_busy}, 0);
      chk("rst_mid_sel", 32'(o_sel), NREQ - 1);
      spur = '0;
      repeat (3) begin
         adv(3'b111, 1'b0);
         spur |= o_done | o_abort;
      end
      chk("rst_no_pulse", 32'(spur), 0);
      rst_n      = 1'b1;
      model_last = NREQ - 1;
      fall_valid = 1'b0;
      exp_frames = 0;
      exp_tmo    = 0;
      do_frame(3'b111, 2, 3, 1'b0, 1'b0, w, s);
      chk("post_reset_first", s, 0);

      // Randomized frames
      for (int i = 0; i < 40; i++) begin
         rq = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         do_frame(rq, $urandom_range(1, TMO), $urandom_range(1, 20),
                  ($urandom_range(0, 4) == 0), $urandom_range(0, 1), w, s);
      end

`ifdef ETH_TX_SCHED_STATS_EN
      for (int i = 0; i < 300; i++) begin
         rq = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         do_frame(rq, 0, 0, 1'b1, 1'b0, w, s);
      end
      chk("tmo_cnt_sat", 32'(o_tmo_cnt), exp_tmo);
      chk("tmo_cnt_255", 32'(o_tmo_cnt), 255);
      chk("frame_cnt", 32'(o_frame_cnt), exp_frames & 32'hFFFF);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
